// File: rtl/i2s_rx.sv
// Slave-side I2S receiver: oversamples BCLK/LRCLK/SDATA on clk.
// It deserialises left/right PCM words and flags short slots.
module i2s_rx #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdata,
    input  logic              err_clr,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              valid,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        SYNC,
        SHIFT,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] DW   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [1:0]        bclk_q;
    logic [1:0]        lr_q;
    logic [1:0]        sd_q;
    logic              bclk_d;
    logic              rise;
    logic              lr_s;
    logic              sd_s;
    logic              change;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sreg;
    logic              lr_prev;
    logic              primed;
    logic              left_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_q <= '0;
            lr_q   <= '0;
            sd_q   <= '0;
            bclk_d <= 1'b0;
        end else begin
            bclk_q <= {bclk_q[0], bclk};
            lr_q   <= {lr_q[0], lrclk};
            sd_q   <= {sd_q[0], sdata};
            bclk_d <= bclk_q[1];
        end
    end

    assign lr_s   = lr_q[1];
    assign sd_s   = sd_q[1];
    assign rise   = bclk_q[1] & ~bclk_d;
    assign change = rise & primed & (lr_s != lr_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SYNC;
            cnt        <= '0;
            sreg       <= '0;
            lr_prev    <= 1'b0;
            primed     <= 1'b0;
            left_ok    <= 1'b0;
            left_data  <= '0;
            right_data <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (err_clr)
                frame_err <= 1'b0;
            if (rise) begin
                // First rise after reset only learns the current LRCLK level,
                // so a slot already in progress never looks like a boundary.
                if (!primed) begin
                    primed  <= 1'b1;
                    lr_prev <= lr_s;
                end else if (change) begin
                    lr_prev <= lr_s;
                    cnt     <= '0;
                    sreg    <= '0;
                    state   <= SHIFT;
                    if (state != SYNC) begin
                        if (cnt >= DW) begin
                            if (lr_s) begin
                                left_data <= sreg;
                                left_ok   <= 1'b1;
                            end else begin
                                right_data <= sreg;
                                valid      <= left_ok;
                                left_ok    <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            left_ok   <= 1'b0;
                        end
                    end
                end else begin
                    if (cnt != CMAX)
                        cnt <= cnt + ONE;
                    if (state == SHIFT && cnt < DW) begin
                        sreg <= {sreg[DATA_W-2:0], sd_s};
                        if (cnt + ONE == DW)
                            state <= HOLD;
                    end
                end
            end
        end
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Slave-side I2S serial receiver. It is the receiving end of the audio frame that the design's LRCLK/BCLK generators drive.
- Samples external BCLK, LRCLK and SDATA with the system clock. Deserialises one left and one right PCM word per frame.
- Presents the two words in parallel with a one-cycle valid strobe to downstream logic, e.g. pad/hit detection or loopback to the DAC path.

Parameters:
- DATA_W, 16, captured bits per channel, MSB first; legal range 8..32.
- CNT_W, 6, width of the per-slot BCLK counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock; must be at least 4x BCLK frequency.
- rst  in  1  asynchronous reset, active-high.
- bclk  in  1  serial bit clock, asynchronous to clk.
- lrclk  in  1  word select, asynchronous to clk; 0 = left, 1 = right.
- sdata  in  1  serial data, MSB first, asynchronous to clk.
- left_data  out  DATA_W  last complete left word.
- right_data  out  DATA_W  last complete right word.
- valid  out  1  one-clk pulse when a new left/right pair is available.
- frame_err  out  1  sticky flag: a slot was shorter than DATA_W+1 BCLKs.
- err_clr  in  1  synchronous clear of frame_err.

Behaviour:
- Reset (async, rst=1): left_data=0, right_data=0, valid=0, frame_err=0, FSM=SYNC, bit counter=0, shift register=0, lr_prev=0. All sync flops are cleared.
- Input conditioning:
  - bclk, lrclk and sdata each pass through a 2-flop synchroniser.
  - A BCLK rise event (bclk_s prev 0, now 1) is a one-clk internal strobe.
  - lrclk_s and sdata_s are sampled only on rise events.
- Boundary detection: on a rise where sampled lrclk != lr_prev, it is a "change rise"; lr_prev then updates.
  - Per I2S, the bit on a change rise is the LSB of the previous word and is ignored.
  - The MSB of the new word arrives on the next rise.
- Bit counter: set to 0 on a change rise, otherwise +1 on each rise, saturating at all-ones.
- FSM states:
  - SYNC: after reset, ignore data until the first change rise, then go to SHIFT. No words, no valid, no error.
  - SHIFT: on each non-change rise with counter+1 in 1..DATA_W, shift sdata_s into the LSB of the shift register. When DATA_W bits are captured, go to HOLD.
  - HOLD: ignore further bits (slot padding) until the change rise.
- Commit, on any change rise while not in SYNC:
  - If the counter before the change was >= DATA_W (DATA_W bits captured), the shift register is committed to the channel just ended. lrclk 0->1 ends left: left_data updates. lrclk 1->0 ends right: right_data updates.
  - If fewer than DATA_W bits were captured (short slot), the word is discarded, frame_err sets, and the output register keeps its old value.
  - In all cases the shift register clears and the FSM goes to SHIFT.
- valid:
  - Pulses 1 clk on the cycle after a successful right-channel commit, but only if the preceding left slot in the same frame also committed successfully.
  - Output registers update on the commit cycle, so data is stable when valid is high and holds until the next commit.
  - Latency: valid is 1 clk after the clk in which the right-ending change rise is detected. That is about 3 clk after the physical BCLK edge, including the synchroniser.
- frame_err: sticky.
  - err_clr=1 clears it on the next clk.
  - If err_clr and a new error occur in the same cycle, the error wins and frame_err stays 1.
- LRCLK toggling without BCLK is not seen; nothing happens.
- A stuck BCLK leaves the FSM waiting indefinitely, with no timeout.
- Slot length above 2^CNT_W-1 is legal; the counter saturates and behaviour is unchanged.
- Reset asserted mid-frame aborts the partial word. The FSM returns to SYNC, so the first partially observed slot after reset is never committed.

Test Plan:
- Standard frame, DATA_W=16, 32-BCLK slots, clk=8x BCLK: send left=0xA5C3, right=0x1234 -> after first full frame, exactly one valid pulse with left_data=0xA5C3, right_data=0x1234; frame_err=0.
- Padding ignored: same frame with all padding bits (slot bits 17..31) driven 1 -> outputs still 0xA5C3/0x1234.
- Startup sync: release reset mid right slot, then send two frames (0x1111/0x2222, 0x3333/0x4444) -> first valid carries 0x1111/0x2222; no valid for the partial slot.
- Short slot: left slot of only 10 BCLKs, then valid right 0x5555 -> frame_err=1, no valid, left_data unchanged; next good frame gives valid. err_clr pulse -> frame_err=0 the next clk.
- Reset mid-word: assert rst after 8 bits of left -> all outputs 0 immediately (asynchronously); after release, the next complete frame is decoded correctly.
- Minimum slot: DATA_W=16 with 17-BCLK slots, alternating 0xFFFF/0x0001 -> correct words and valid every frame, frame_err=0.
